// File: rtl/currctrl_pkg.sv
// Shared CurrCTRL RAM geometry and master identifiers for the s2-port arbiter.
package currctrl_pkg;

    localparam int unsigned CC_RAM_ADDR_W = 8;
    localparam int unsigned CC_RAM_DATA_W = 32;
    localparam int unsigned CC_RAM_BE_W   = 4;

    typedef enum logic {
        M_PLAYBACK = 1'b0,
        M_LOGGER   = 1'b1
    } master_id_e;

    function automatic master_id_e other_master(input master_id_e m);
        return (m == M_PLAYBACK) ? M_LOGGER : M_PLAYBACK;
    endfunction

endpackage

// File: rtl/currctrl_rr_arb2.sv
// Two-way round-robin grant with bounded bursts and per-master lock.
module currctrl_rr_arb2
    import currctrl_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    master_id_e owner;
    master_id_e gnt_id;
    logic [3:0] burst_cnt;
    logic       owner_lock;
    logic       keep_owner;
    logic       grant_any;

    always_comb begin
        owner_lock = (owner == M_PLAYBACK) ? lock0 : lock1;
        keep_owner = owner_lock || (burst_cnt < BURST_LIM);
        gnt_id     = owner;
        if (req0 && req1)
            gnt_id = keep_owner ? owner : other_master(owner);
        else if (req0)
            gnt_id = M_PLAYBACK;
        else if (req1)
            gnt_id = M_LOGGER;
        // Gating with reset_n keeps every grant (and thus any RAM write) off while in reset.
        grant_any = (req0 || req1) && reset_n;
        gnt0      = grant_any && (gnt_id == M_PLAYBACK);
        gnt1      = grant_any && (gnt_id == M_LOGGER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= M_PLAYBACK;
            burst_cnt <= '0;
        end else if (!grant_any) begin
            burst_cnt <= '0;
        end else if (gnt_id == owner) begin
            if (burst_cnt != '1)
                burst_cnt <= burst_cnt + 4'd1;
        end else begin
            owner     <= gnt_id;
            burst_cnt <= 4'd1;
        end
    end

endmodule

// File: rtl/currctrl_ram_arbiter.sv
// Shares the CurrCTRL RAM s2 port between playback (m0) and logger (m1) masters.
module currctrl_ram_arbiter
    import currctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = CC_RAM_ADDR_W,
    parameter int unsigned DATA_W    = CC_RAM_DATA_W,
    parameter int unsigned BE_W      = CC_RAM_BE_W,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [BE_W-1:0]   m0_be,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [BE_W-1:0]   m1_be,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic       rd_push;
    logic       rd_valid [RD_LAT];
    master_id_e rd_id    [RD_LAT];

    currctrl_rr_arb2 #(
        .BURST_MAX(BURST_MAX)
    ) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req0   (m0_req),
        .req1   (m1_req),
        .lock0  (m0_lock),
        .lock1  (m1_lock),
        .gnt0   (m0_gnt),
        .gnt1   (m1_gnt)
    );

    // With no grant the mux rests on m0's fields; chipselect alone qualifies them.
    always_comb begin
        ram_address    = m1_gnt ? m1_addr  : m0_addr;
        ram_writedata  = m1_gnt ? m1_wdata : m0_wdata;
        ram_byteenable = m1_gnt ? m1_be    : m0_be;
        ram_chipselect = m0_gnt | m1_gnt;
        ram_write      = (m0_gnt & m0_we) | (m1_gnt & m1_we);
        ram_clken      = 1'b1;
        rd_push        = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                rd_valid[i] <= 1'b0;
                rd_id[i]    <= M_PLAYBACK;
            end
        end else begin
            rd_valid[0] <= rd_push;
            rd_id[0]    <= m1_gnt ? M_LOGGER : M_PLAYBACK;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rd_valid[i] <= rd_valid[i-1];
                rd_id[i]    <= rd_id[i-1];
            end
        end
    end

    always_comb begin
        m0_rvalid = rd_valid[RD_LAT-1] && (rd_id[RD_LAT-1] == M_PLAYBACK);
        m1_rvalid = rd_valid[RD_LAT-1] && (rd_id[RD_LAT-1] == M_LOGGER);
        m0_rdata  = ram_readdata;
        m1_rdata  = ram_readdata;
    end

endmodule
